// File: rtl/rsa_seq_ctrl.sv
// Sequencer for one Montgomery modular exponentiation C = M^E mod N.
// Runs rtMod twice (R mod N, then R^2 mod N) and modInv once (nprime0).
// Then it streams the operands word-serially into ModExp, waits for
// completion, and reassembles the result words.
module rsa_seq_ctrl #(
  parameter int WIDTH    = 4096,
  parameter int DW       = 64,
  parameter int NWORDS   = WIDTH / DW,
  parameter int EXP_DONE = 9,
  parameter int TIMEOUT  = 2**24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [WIDTH-1:0] message,
  input  logic [WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0] modulus,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] n_out,
  output logic             rt_go,
  output logic             rt_mode,
  input  logic [WIDTH-1:0] rt_r,
  input  logic             rt_done,
  output logic             inv_go,
  input  logic [63:0]      inv_val,
  input  logic             inv_valid,
  output logic [DW-1:0]    m_buf,
  output logic [DW-1:0]    e_buf,
  output logic [DW-1:0]    n_buf,
  output logic [DW-1:0]    r_buf,
  output logic [DW-1:0]    t_buf,
  output logic [63:0]      nprime0,
  output logic             startInput,
  output logic             startCompute,
  output logic             getResult,
  input  logic [4:0]       exp_state,
  input  logic [DW-1:0]    res_out
);

  localparam int CW = $clog2(NWORDS) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int BW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE, CALC_R, CALC_T, CALC_N0, SEND, COMPUTE, READ, FIN
  } state_t;

  state_t           state, next_state;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] m_reg, e_reg, r_reg, t_reg;
  logic [BW-1:0]    base;
  logic             wait_state, timer_max, timeout_hit;

  assign wait_state = (state == CALC_R) || (state == CALC_T) ||
                      (state == CALC_N0) || (state == COMPUTE);
  assign timer_max  = (timer == TW'(TIMEOUT - 1));
  assign base       = BW'(cnt) * BW'(DW);

  assign busy         = (state != IDLE);
  assign done         = (state == FIN);
  assign startInput   = (state == SEND);
  assign startCompute = (state == COMPUTE) || (state == READ);
  assign getResult    = (state == COMPUTE) || (state == READ);
  assign m_buf        = startInput ? m_reg[base +: DW] : '0;
  assign e_buf        = startInput ? e_reg[base +: DW] : '0;
  assign n_buf        = startInput ? n_out[base +: DW] : '0;
  assign r_buf        = startInput ? r_reg[base +: DW] : '0;
  assign t_buf        = startInput ? t_reg[base +: DW] : '0;

  // Next-state selection; a completion event beats a simultaneous timeout
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    case (state)
      IDLE:    if (go && modulus[0]) next_state = CALC_R;
      CALC_R:  if (rt_done) next_state = CALC_T;
               else if (timer_max) begin timeout_hit = 1'b1; next_state = IDLE; end
      CALC_T:  if (rt_done) next_state = CALC_N0;
               else if (timer_max) begin timeout_hit = 1'b1; next_state = IDLE; end
      CALC_N0: if (inv_valid) next_state = SEND;
               else if (timer_max) begin timeout_hit = 1'b1; next_state = IDLE; end
      SEND:    if (cnt == CW'(NWORDS - 1)) next_state = COMPUTE;
      COMPUTE: if (exp_state == 5'(EXP_DONE)) next_state = READ;
               else if (timer_max) begin timeout_hit = 1'b1; next_state = IDLE; end
      READ:    if (cnt == CW'(NWORDS - 1)) next_state = FIN;
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Wait timer restarts on every state change and only runs in wait states
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 timer <= '0;
    else if (next_state != state) timer <= '0;
    else if (wait_state)          timer <= timer + 1'b1;
  end

  // Word counter cleared on entry to SEND/READ, advanced once per word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if ((next_state != state) && ((next_state == SEND) || (next_state == READ)))
      cnt <= '0;
    else if ((state == SEND) || (state == READ))
      cnt <= cnt + 1'b1;
  end

  // Operand, intermediate and result capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_reg   <= '0;
      e_reg   <= '0;
      n_out   <= '0;
      r_reg   <= '0;
      t_reg   <= '0;
      nprime0 <= '0;
      result  <= '0;
    end else begin
      if ((state == IDLE) && go) begin
        m_reg <= message;
        e_reg <= exponent;
        n_out <= modulus;
      end
      if ((state == CALC_R) && rt_done)     r_reg   <= rt_r;
      if ((state == CALC_T) && rt_done)     t_reg   <= rt_r;
      if ((state == CALC_N0) && inv_valid)  nprime0 <= inv_val;
      if (state == READ)                    result[base +: DW] <= res_out;
    end
  end

  // Registered one-cycle strobes and the rtMod mode select
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err     <= 1'b0;
      rt_go   <= 1'b0;
      inv_go  <= 1'b0;
      rt_mode <= 1'b0;
    end else begin
      err    <= ((state == IDLE) && go && !modulus[0]) || timeout_hit;
      rt_go  <= ((state == IDLE) && go && modulus[0]) || ((state == CALC_R) && rt_done);
      inv_go <= (state == CALC_T) && rt_done;
      if ((state == CALC_R) && rt_done)
        rt_mode <= 1'b1;
      else if ((next_state != CALC_R) && (next_state != CALC_T))
        rt_mode <= 1'b0;
    end
  end

endmodule
